// File: rtl/wb_copy_pkg.sv
// Shared types and constants for the Wishbone block-copy initiator.
// State encoding, bus constants and the default watchdog limit live here.
// Imported by wb_copy_master and wb_copy_timeout.
package wb_copy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_RGAP  = 3'd2,
        ST_WRITE = 3'd3,
        ST_WGAP  = 3'd4
    } state_t;

    localparam logic [3:0]  WB_SEL_ALL      = 4'hF;
    localparam logic [31:0] WORD_STRIDE     = 32'd4;
    localparam int          DEFAULT_TIMEOUT = 1023;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/wb_copy_timeout.sv
// Purpose: watchdog counting cycles a strobe waits without an ack.
// Latency: count is registered; expired is a decode of the count and the current ack.
// Backpressure: none; saturates at TIMEOUT until cleared.
module wb_copy_timeout
    import wb_copy_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic ack,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt;

    // Count stalled strobe cycles; restart whenever the master leaves a bus phase.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable && !ack && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // An ack arriving in the same cycle the limit is hit wins over the abort.
    assign expired = enable && !ack && (cnt == LIMIT);

endmodule

// File: rtl/wb_copy_master.sv
// Purpose: Wishbone classic initiator copying LEN words src->dst, one read then one write each.
// Latency: stb rises the cycle after accept; 4 cycles/word with a zero-wait slave, done the cycle after last ack.
// Backpressure: cmd_ready_o only in IDLE; waits on ack (aborts with err_o when WB_COPY_TIMEOUT_EN is defined).
module wb_copy_master
    import wb_copy_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [31:0]      cmd_src_i,
    input  logic [31:0]      cmd_dst_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [LEN_W-1:0] xfer_cnt_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic [31:0]      wbm_dat_i
);

    state_t            state;
    logic [31:0]       src;
    logic [31:0]       dst;
    logic [31:0]       data;
    logic [LEN_W-1:0]  remaining;
    logic              to_expired;

`ifdef WB_COPY_TIMEOUT_EN
    logic to_clear;

    // The watchdog only runs while a strobe is out; gaps and IDLE hold it at zero.
    assign to_clear = !((state == ST_READ) || (state == ST_WRITE));

    wb_copy_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clear   (to_clear),
        .enable  (!to_clear),
        .ack     (wbm_ack_i),
        .expired (to_expired)
    );
`else
    // No watchdog: the bus waits forever for ack and err_o can never fire.
    // TIMEOUT is referenced only so both builds share one parameter list.
    assign to_expired = 1'b0 & (TIMEOUT != 0);
`endif

    // Copy sequencer: every output is a register updated on state transitions.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= ST_IDLE;
            src         <= '0;
            dst         <= '0;
            data        <= '0;
            remaining   <= '0;
            xfer_cnt_o  <= '0;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= '0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        src        <= word_align(cmd_src_i);
                        dst        <= word_align(cmd_dst_i);
                        remaining  <= cmd_len_i;
                        xfer_cnt_o <= '0;
                        if (cmd_len_i == '0) begin
                            // Empty copy: report completion without touching the bus.
                            done_o <= 1'b1;
                        end else begin
                            state       <= ST_READ;
                            cmd_ready_o <= 1'b0;
                            busy_o      <= 1'b1;
                            wbm_cyc_o   <= 1'b1;
                            wbm_stb_o   <= 1'b1;
                            wbm_we_o    <= 1'b0;
                            wbm_sel_o   <= WB_SEL_ALL;
                            wbm_adr_o   <= word_align(cmd_src_i);
                        end
                    end
                end

                ST_READ: begin
                    if (wbm_ack_i) begin
                        data      <= wbm_dat_i;
                        state     <= ST_RGAP;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_sel_o <= '0;
                    end else if (to_expired) begin
                        state       <= ST_IDLE;
                        err_o       <= 1'b1;
                        cmd_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        wbm_sel_o   <= '0;
                    end
                end

                ST_RGAP: begin
                    state     <= ST_WRITE;
                    wbm_cyc_o <= 1'b1;
                    wbm_stb_o <= 1'b1;
                    wbm_we_o  <= 1'b1;
                    wbm_sel_o <= WB_SEL_ALL;
                    wbm_adr_o <= dst;
                    wbm_dat_o <= data;
                end

                ST_WRITE: begin
                    if (wbm_ack_i) begin
                        src        <= src + WORD_STRIDE;
                        dst        <= dst + WORD_STRIDE;
                        remaining  <= remaining - 1'b1;
                        xfer_cnt_o <= xfer_cnt_o + 1'b1;
                        wbm_cyc_o  <= 1'b0;
                        wbm_stb_o  <= 1'b0;
                        wbm_we_o   <= 1'b0;
                        wbm_sel_o  <= '0;
                        if (remaining == LEN_W'(1)) begin
                            state       <= ST_IDLE;
                            done_o      <= 1'b1;
                            cmd_ready_o <= 1'b1;
                            busy_o      <= 1'b0;
                        end else begin
                            state <= ST_WGAP;
                        end
                    end else if (to_expired) begin
                        state       <= ST_IDLE;
                        err_o       <= 1'b1;
                        cmd_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        wbm_we_o    <= 1'b0;
                        wbm_sel_o   <= '0;
                    end
                end

                ST_WGAP: begin
                    // src already points at the next word after the write ack.
                    state     <= ST_READ;
                    wbm_cyc_o <= 1'b1;
                    wbm_stb_o <= 1'b1;
                    wbm_we_o  <= 1'b0;
                    wbm_sel_o <= WB_SEL_ALL;
                    wbm_adr_o <= src;
                end

                default: begin
                    state       <= ST_IDLE;
                    cmd_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                    wbm_cyc_o   <= 1'b0;
                    wbm_stb_o   <= 1'b0;
                    wbm_we_o    <= 1'b0;
                    wbm_sel_o   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_copy_master.sv
// Directed bench for wb_copy_master with a programmable-latency Wishbone slave.
// Slave read data is the bitwise inverse of the address, so each write value is known by hand.
// Timeout scenario is included only when WB_COPY_TIMEOUT_EN is defined.
module tb_wb_copy_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_src = '0;
    logic [31:0] cmd_dst = '0;
    logic [15:0] cmd_len = '0;
    logic        busy, done, err;
    logic [15:0] xfer_cnt;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat, rdat;
    logic        ack;

    always #5 clk = ~clk;

    wb_copy_master #(
        .LEN_W   (16),
        .TIMEOUT (8)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_src_i   (cmd_src),
        .cmd_dst_i   (cmd_dst),
        .cmd_len_i   (cmd_len),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .xfer_cnt_o  (xfer_cnt),
        .wbm_cyc_o   (cyc),
        .wbm_stb_o   (stb),
        .wbm_we_o    (we),
        .wbm_sel_o   (sel),
        .wbm_adr_o   (adr),
        .wbm_dat_o   (wdat),
        .wbm_ack_i   (ack),
        .wbm_dat_i   (rdat)
    );

    // Slave: acks after ack_delay stalled cycles; can refuse writes beyond wr_limit.
    int ack_delay = 0;
    int wait_cnt  = 0;
    int wr_total  = 0;
    int wr_limit  = 1000000;

    assign ack  = cyc && stb && (wait_cnt == ack_delay) && !(we && (wr_total >= wr_limit));
    assign rdat = ~adr;

    always @(posedge clk) begin
        if (stb && !ack) wait_cnt <= wait_cnt + 1;
        else             wait_cnt <= 0;
        if (stb && ack && we) wr_total <= wr_total + 1;
    end

    // Monitor, sampled mid-cycle.
    int cyc_n = 0, done_cnt = 0, err_cnt = 0, done_cyc = 0;
    int gap_viol = 0, stab_viol = 0;
    bit cyc_seen = 0;
    logic        prev_stb = 0, prev_ack = 0;
    logic [31:0] prev_adr = 0, prev_dat = 0;
    logic [31:0] radr_q[$], wadr_q[$], wdat_q[$];

    always @(negedge clk) begin
        cyc_n = cyc_n + 1;
        if (done) begin done_cnt = done_cnt + 1; done_cyc = cyc_n; end
        if (err) err_cnt = err_cnt + 1;
        if (cyc) cyc_seen = 1;
        if (prev_ack && stb) gap_viol = gap_viol + 1;
        if (stb && prev_stb && !prev_ack && ((adr != prev_adr) || (we && (wdat != prev_dat))))
            stab_viol = stab_viol + 1;
        if (stb && ack) begin
            if (we) begin wadr_q.push_back(adr); wdat_q.push_back(wdat); end
            else radr_q.push_back(adr);
        end
        prev_stb = stb; prev_ack = stb && ack; prev_adr = adr; prev_dat = wdat;
    end

    int checks = 0;
    int errors = 0;
    int accept_cyc = 0;
    int base = 0;
    bit ok;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_DEAD;
    endfunction

    task automatic clear_logs();
        radr_q.delete(); wadr_q.delete(); wdat_q.delete();
        gap_viol = 0; stab_viol = 0; cyc_seen = 0;
        base = done_cnt + err_cnt;
    endtask

    task automatic issue(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        @(negedge clk); #2;
        cmd_valid = 1'b1; cmd_src = s; cmd_dst = d; cmd_len = l;
        @(posedge clk);
        accept_cyc = cyc_n;
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit seen);
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt + err_cnt > base) begin seen = 1; break; end
            @(negedge clk); #1;
        end
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy",  busy, 0);
        chk("rst_cyc",   cyc, 0);
        chk("rst_sel",   sel, 0);
        chk("rst_xfer",  xfer_cnt, 0);
        rst = 1'b0;

        // Zero-wait copy of three words.
        ack_delay = 0; clear_logs();
        issue(32'h3800_0000, 32'h3800_0100, 16'd3);
        wait_end(200, ok);
        chk("t1_end", ok, 1);
        chk("t1_lat", done_cyc - accept_cyc, 12);
        chk("t1_xfer", xfer_cnt, 3);
        chk("t1_nrd", radr_q.size(), 3);
        chk("t1_rd2", qget(radr_q, 2), 32'h3800_0008);
        chk("t1_wa0", qget(wadr_q, 0), 32'h3800_0100);
        chk("t1_wa1", qget(wadr_q, 1), 32'h3800_0104);
        chk("t1_wa2", qget(wadr_q, 2), 32'h3800_0108);
        chk("t1_wd0", qget(wdat_q, 0), 32'hC7FF_FFFF);
        chk("t1_wd1", qget(wdat_q, 1), 32'hC7FF_FFFB);
        chk("t1_wd2", qget(wdat_q, 2), 32'hC7FF_FFF7);
        chk("t1_ready", cmd_ready, 1);
        chk("t1_busy", busy, 0);
        chk("t1_gap", gap_viol, 0);

        // Slow slave, 11 wait states per access.
        ack_delay = 11; clear_logs();
        issue(32'h3800_0010, 32'h3800_0200, 16'd2);
        wait_end(400, ok);
        chk("t2_end", ok, 1);
        chk("t2_lat", done_cyc - accept_cyc, 52);
        repeat (5) @(negedge clk);
        #1;
        chk("t2_ndone", done_cnt - base, 1);
        chk("t2_stable", stab_viol, 0);
        chk("t2_gap", gap_viol, 0);
        chk("t2_wa1", qget(wadr_q, 1), 32'h3800_0204);
        chk("t2_wd0", qget(wdat_q, 0), 32'hC7FF_FFEF);
        chk("t2_wd1", qget(wdat_q, 1), 32'hC7FF_FFEB);

        // Empty command.
        ack_delay = 0; clear_logs();
        issue(32'h3800_0000, 32'h3800_0100, 16'd0);
        wait_end(20, ok);
        chk("t3_end", ok, 1);
        chk("t3_lat", done_cyc - accept_cyc, 1);
        repeat (4) @(negedge clk);
        #1;
        chk("t3_cyc", cyc_seen, 0);
        chk("t3_xfer", xfer_cnt, 0);

        // Address wrap at the top of the space.
        clear_logs();
        issue(32'hFFFF_FFFC, 32'h3800_0400, 16'd2);
        wait_end(100, ok);
        chk("t4_end", ok, 1);
        chk("t4_rd0", qget(radr_q, 0), 32'hFFFF_FFFC);
        chk("t4_rd1", qget(radr_q, 1), 32'h0000_0000);
        chk("t4_wd0", qget(wdat_q, 0), 32'h0000_0003);
        chk("t4_wd1", qget(wdat_q, 1), 32'hFFFF_FFFF);

        // Unaligned addresses are truncated to the word.
        clear_logs();
        issue(32'h3800_0003, 32'h3800_0503, 16'd1);
        wait_end(100, ok);
        chk("t5_end", ok, 1);
        chk("t5_rd0", qget(radr_q, 0), 32'h3800_0000);
        chk("t5_wa0", qget(wadr_q, 0), 32'h3800_0500);
        chk("t5_wd0", qget(wdat_q, 0), 32'hC7FF_FFFF);

        // Reset during a write wait state.
        ack_delay = 20; clear_logs();
        issue(32'h3800_0020, 32'h3800_0600, 16'd1);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (stb && we) begin ok = 1; break; end
        end
        chk("t6_inwr", ok, 1);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_cyc", cyc, 0);
        chk("t6_stb", stb, 0);
        chk("t6_we",  we, 0);
        chk("t6_sel", sel, 0);
        chk("t6_adr", adr, 0);
        chk("t6_dat", wdat, 0);
        chk("t6_busy", busy, 0);
        chk("t6_xfer", xfer_cnt, 0);
        chk("t6_ready", cmd_ready, 1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("t6_nopulse", done_cnt + err_cnt - base, 0);
        chk("t6_nowr", wadr_q.size(), 0);
        ack_delay = 0; clear_logs();
        issue(32'h3800_0030, 32'h3800_0700, 16'd1);
        wait_end(100, ok);
        chk("t6_end", ok, 1);
        chk("t6_done", done_cnt - base, 1);
        chk("t6_xfer1", xfer_cnt, 1);
        chk("t6_wa0", qget(wadr_q, 0), 32'h3800_0700);
        chk("t6_wd0", qget(wdat_q, 0), 32'hC7FF_FFCF);

`ifdef WB_COPY_TIMEOUT_EN
        // Slave never acks the second write; the watchdog aborts.
        ack_delay = 0; clear_logs();
        wr_limit = wr_total + 1;
        issue(32'h3800_0040, 32'h3800_0800, 16'd2);
        wait_end(200, ok);
        chk("t7_end", ok, 1);
        repeat (2) @(negedge clk);
        #1;
        chk("t7_err", err_cnt, 1);
        chk("t7_nodone", done_cnt - base, 0);
        chk("t7_xfer", xfer_cnt, 1);
        chk("t7_cyc", cyc, 0);
        chk("t7_ready", cmd_ready, 1);
        wr_limit = 1000000;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
